// File: rtl/syn_filt_pkg.sv
// Shared constants for the order-10 synthesis filter: subframe geometry and
// the scratch-memory layout it shares with convolve.
package syn_filt_pkg;

   localparam int L_SUBFR = 40;
   localparam int M       = 10;

   localparam logic [10:0] A_ADDR   = 11'd0;
   localparam logic [10:0] X_ADDR   = 11'd16;
   localparam logic [10:0] Y_ADDR   = 11'd64;
   localparam logic [10:0] MEM_ADDR = 11'd112;

   localparam logic [15:0] SHL_BITS = 16'd3;

endpackage

// File: rtl/syn_filt_if.sv
// Scratch-memory port, control handshake and external L_mult/L_msu/L_shl
// operand lines of syn_filt; master is the filter, slave its environment.
interface syn_filt_if;

   logic        start;
   logic        update;
   logic        done;
   logic [31:0] memIn;
   logic [10:0] memReadAddr;
   logic        memWriteEn;
   logic [10:0] memWriteAddr;
   logic [31:0] memOut;
   logic [15:0] L_multOutA;
   logic [15:0] L_multOutB;
   logic [31:0] L_multIn;
   logic [15:0] L_msuOutA;
   logic [15:0] L_msuOutB;
   logic [31:0] L_msuOutC;
   logic [31:0] L_msuIn;
   logic [31:0] L_shlOutVar1;
   logic [15:0] L_shlNumBitsOut;
   logic [31:0] L_shlIn;

   modport master (
      input  start, update, memIn, L_multIn, L_msuIn, L_shlIn,
      output done, memReadAddr, memWriteEn, memWriteAddr, memOut,
             L_multOutA, L_multOutB, L_msuOutA, L_msuOutB, L_msuOutC,
             L_shlOutVar1, L_shlNumBitsOut
   );

   modport slave (
      output start, update, memIn, L_multIn, L_msuIn, L_shlIn,
      input  done, memReadAddr, memWriteEn, memWriteAddr, memOut,
             L_multOutA, L_multOutB, L_msuOutA, L_msuOutB, L_msuOutC,
             L_shlOutVar1, L_shlNumBitsOut
   );

endinterface

// File: rtl/syn_filt_round.sv
// Saturating round of a Q31 accumulator to Q15: adds one half LSB of the
// upper word and clamps a positive overflow to 0x7FFF.
module syn_filt_round (
   input  logic signed [31:0] din,
   output logic signed [15:0] dout
);

   function automatic logic signed [15:0] sat_round(input logic signed [31:0] v);
      logic [31:0] sum;
      sum = v + 32'sd32768;
      if (!v[31] && sum[31]) return 16'sh7FFF;
      return sum[31:16];
   endfunction

   assign dout = sat_round(din);

endmodule

// File: rtl/syn_filt.sv
// G.729 Syn_filt: order-10 all-pole synthesis over one 40-sample subframe,
// sequenced over shared scratch memory and external basic-op units.
module syn_filt
   import syn_filt_pkg::*;
#(
   parameter logic [10:0] A_BASE   = A_ADDR,
   parameter logic [10:0] X_BASE   = X_ADDR,
   parameter logic [10:0] Y_BASE   = Y_ADDR,
   parameter logic [10:0] MEM_BASE = MEM_ADDR
) (
   input logic        clk,
   input logic        reset,
   syn_filt_if.master bus
);

   typedef enum logic [3:0] {
      S_INIT, S_RDA0, S_RDX, S_MULT, S_RDY, S_MSU,
      S_STORE, S_UPD_RD, S_UPD_WR, S_DONE
   } state_t;

   localparam logic [5:0] I_LAST = 6'(L_SUBFR - 1);
   localparam logic [3:0] J_LAST = 4'(M);
   localparam logic [3:0] K_LAST = 4'(M - 1);

   state_t             state, state_nxt;
   logic [5:0]         i;
   logic [3:0]         j, k;
   logic signed [31:0] acc;
   logic signed [15:0] a_reg;
   logic               upd_reg;
   logic signed [15:0] y_rnd;

   syn_filt_round u_round (.din(bus.L_shlIn), .dout(y_rnd));

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_INIT;
         i       <= '0;
         j       <= '0;
         k       <= '0;
         acc     <= '0;
         a_reg   <= '0;
         upd_reg <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_INIT: begin
               i <= '0;
               if (bus.start) upd_reg <= bus.update;
            end
            S_RDX:  a_reg <= bus.memIn[15:0];
            S_MULT: begin
               acc <= bus.L_multIn;
               j   <= 4'd1;
            end
            S_RDY:  a_reg <= bus.memIn[15:0];
            S_MSU: begin
               acc <= bus.L_msuIn;
               if (j < J_LAST) j <= j + 4'd1;
            end
            S_STORE: begin
               if (i < I_LAST) i <= i + 6'd1;
               else if (upd_reg) k <= '0;
            end
            S_UPD_WR: if (k < K_LAST) k <= k + 4'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt           = state;
      bus.done            = 1'b0;
      bus.memReadAddr     = '0;
      bus.memWriteEn      = 1'b0;
      bus.memWriteAddr    = '0;
      bus.memOut          = '0;
      bus.L_multOutA      = '0;
      bus.L_multOutB      = '0;
      bus.L_msuOutA       = '0;
      bus.L_msuOutB       = '0;
      bus.L_msuOutC       = '0;
      bus.L_shlOutVar1    = '0;
      bus.L_shlNumBitsOut = '0;
      case (state)
         S_INIT: if (bus.start) state_nxt = S_RDA0;
         S_RDA0: begin
            bus.memReadAddr = A_BASE;
            state_nxt       = S_RDX;
         end
         S_RDX: begin
            bus.memReadAddr = X_BASE + 11'(i);
            state_nxt       = S_MULT;
         end
         S_MULT: begin
            bus.L_multOutA  = a_reg;
            bus.L_multOutB  = bus.memIn[15:0];
            bus.memReadAddr = A_BASE + 11'd1;
            state_nxt       = S_RDY;
         end
         S_RDY: begin
            // Taps reaching before sample 0 come from the filter memory tail.
            if (i >= 6'(j)) bus.memReadAddr = Y_BASE + 11'(i) - 11'(j);
            else            bus.memReadAddr = MEM_BASE + 11'(M) + 11'(i) - 11'(j);
            state_nxt = S_MSU;
         end
         S_MSU: begin
            bus.L_msuOutC = acc;
            bus.L_msuOutA = a_reg;
            bus.L_msuOutB = bus.memIn[15:0];
            if (j < J_LAST) begin
               bus.memReadAddr = A_BASE + 11'(j) + 11'd1;
               state_nxt       = S_RDY;
            end else begin
               state_nxt = S_STORE;
            end
         end
         S_STORE: begin
            bus.L_shlOutVar1    = acc;
            bus.L_shlNumBitsOut = SHL_BITS;
            bus.memWriteEn      = 1'b1;
            bus.memWriteAddr    = Y_BASE + 11'(i);
            bus.memOut          = {{16{y_rnd[15]}}, y_rnd};
            if (i < I_LAST)   state_nxt = S_RDA0;
            else if (upd_reg) state_nxt = S_UPD_RD;
            else              state_nxt = S_DONE;
         end
         S_UPD_RD: begin
            bus.memReadAddr = Y_BASE + 11'(L_SUBFR - M) + 11'(k);
            state_nxt       = S_UPD_WR;
         end
         S_UPD_WR: begin
            bus.memWriteEn   = 1'b1;
            bus.memWriteAddr = MEM_BASE + 11'(k);
            bus.memOut       = bus.memIn;
            state_nxt        = (k < K_LAST) ? S_UPD_RD : S_DONE;
         end
         S_DONE: begin
            bus.done  = 1'b1;
            state_nxt = S_INIT;
         end
         default: state_nxt = S_INIT;
      endcase
   end

endmodule

// File: tb/tb_syn_filt.sv
// Bench for syn_filt: scratch memory and basic-op models, a reference
// Syn_filt model feeding a write scoreboard, and directed scenarios.
module tb_syn_filt;
   import syn_filt_pkg::*;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        start_s  [2];
   logic        update_s [2];
   logic        done_w   [2];
   logic        we_w     [2];
   logic [10:0] wa_w     [2];
   logic [31:0] wd_w     [2];
   logic [10:0] ra_w     [2];
   logic [31:0] rd_q     [2];
   logic [15:0] ma_w     [2];
   logic [31:0] smem     [2][2048];

   logic        ld_we   = 1'b0;
   bit          ld_g    = 1'b0;
   logic [10:0] ld_addr = '0;
   logic [31:0] ld_data = '0;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [10:0] addr;
      logic [31:0] data;
   } wr_t;
   wr_t exp_q[$];

   logic [15:0] a_m   [11];
   logic [15:0] x_m   [40];
   logic [15:0] mem_m [10];

   function automatic logic [31:0] f_sat(input longint v);
      if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
      if (v < -64'sd2147483648) return 32'h8000_0000;
      return v[31:0];
   endfunction

   function automatic logic [31:0] f_mult(input logic [15:0] a, input logic [15:0] b);
      return f_sat(64'sd2 * longint'($signed(a)) * longint'($signed(b)));
   endfunction

   function automatic logic [31:0] f_msu(input logic [31:0] c, input logic [15:0] a,
                                         input logic [15:0] b);
      return f_sat(longint'($signed(c)) - longint'($signed(f_mult(a, b))));
   endfunction

   function automatic logic [31:0] f_shl(input logic [31:0] v, input logic [15:0] n);
      longint r;
      r = longint'($signed(v));
      for (int b = 0; b < int'(n) && b < 32; b++) begin
         r = r * 2;
         if (r > 64'sd2147483647 || r < -64'sd2147483648) break;
      end
      return f_sat(r);
   endfunction

   function automatic logic [15:0] f_round(input logic [31:0] v);
      logic [31:0] r;
      r = f_sat(longint'($signed(v)) + 64'sd32768);
      return r[31:16];
   endfunction

   function automatic logic [31:0] sx(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gen
      syn_filt_if bus ();
      assign bus.start    = start_s[g];
      assign bus.update   = update_s[g];
      assign bus.memIn    = rd_q[g];
      assign bus.L_multIn = f_mult(bus.L_multOutA, bus.L_multOutB);
      assign bus.L_msuIn  = f_msu(bus.L_msuOutC, bus.L_msuOutA, bus.L_msuOutB);
      assign bus.L_shlIn  = f_shl(bus.L_shlOutVar1, bus.L_shlNumBitsOut);
      assign done_w[g]    = bus.done;
      assign we_w[g]      = bus.memWriteEn;
      assign wa_w[g]      = bus.memWriteAddr;
      assign wd_w[g]      = bus.memOut;
      assign ra_w[g]      = bus.memReadAddr;
      assign ma_w[g]      = bus.L_multOutA;

      syn_filt #(
         .A_BASE  (A_ADDR),
         .X_BASE  ((g == 0) ? X_ADDR : Y_ADDR),
         .Y_BASE  (Y_ADDR),
         .MEM_BASE(MEM_ADDR)
      ) dut (
         .clk  (clk),
         .reset(reset),
         .bus  (bus.master)
      );
   end

   // Registered-read scratch memory per instance, plus a bench load port.
   always @(posedge clk) begin
      rd_q[0] <= smem[0][ra_w[0]];
      rd_q[1] <= smem[1][ra_w[1]];
      if (we_w[0]) smem[0][wa_w[0]] <= wd_w[0];
      if (we_w[1]) smem[1][wa_w[1]] <= wd_w[1];
      if (ld_we)   smem[ld_g][ld_addr] <= ld_data;
   end

   task automatic ld(input bit g, input int a, input logic [31:0] v);
      ld_g    = g;
      ld_addr = 11'(a);
      ld_data = v;
      ld_we   = 1'b1;
      @(negedge clk);
      ld_we   = 1'b0;
   endtask

   task automatic load_case(input bit g, input int a0, input int a1, input int x0,
                            input int xr, input int m9);
      for (int n = 0; n < 11; n++) a_m[n] = (n == 0) ? 16'(a0) : (n == 1) ? 16'(a1) : 16'd0;
      for (int n = 0; n < 40; n++) x_m[n] = (n == 0) ? 16'(x0) : 16'(xr);
      for (int n = 0; n < 10; n++) mem_m[n] = (n == 9) ? 16'(m9) : 16'd0;
      for (int n = 0; n < 11; n++) ld(g, int'(A_ADDR) + n, sx(a_m[n]));
      for (int n = 0; n < 40; n++) ld(g, (g ? int'(Y_ADDR) : int'(X_ADDR)) + n, sx(x_m[n]));
      for (int n = 0; n < 10; n++) ld(g, int'(MEM_ADDR) + n, sx(mem_m[n]));
   endtask

   task automatic model(input bit upd);
      logic [31:0] s;
      logic [15:0] y [40];
      logic [15:0] yy;
      for (int n = 0; n < 40; n++) begin
         s = f_mult(x_m[n], a_m[0]);
         for (int t = 1; t <= 10; t++) begin
            yy = (n >= t) ? y[n-t] : mem_m[10+n-t];
            s  = f_msu(s, a_m[t], yy);
         end
         y[n] = f_round(f_shl(s, 16'd3));
         exp_q.push_back('{addr: 11'(int'(Y_ADDR) + n), data: sx(y[n])});
      end
      if (upd) begin
         for (int q = 0; q < 10; q++) begin
            exp_q.push_back('{addr: 11'(int'(MEM_ADDR) + q), data: sx(y[30+q])});
            mem_m[q] = y[30+q];
         end
      end
   endtask

   task automatic run_job(input bit g, input bit upd, input int lat, input bit mid_start,
                          input string name);
      int  c;
      bit  seen;
      wr_t e;
      exp_q.delete();
      model(upd);
      @(negedge clk);
      n_tests++;
      if (done_w[g] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s done before start: got %b, expected 0", name, done_w[g]);
      end
      start_s[g]  = 1'b1;
      update_s[g] = upd;
      @(negedge clk);
      start_s[g]  = 1'b0;
      update_s[g] = 1'b0;
      c    = 1;
      seen = 1'b0;
      while (!seen && c < 2000) begin
         if (mid_start) start_s[g] = (c == 300);
         if (we_w[g]) begin
            n_tests++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s unexpected write: addr=%0d data=%h", name, wa_w[g], wd_w[g]);
            end else begin
               e = exp_q.pop_front();
               if (wa_w[g] !== e.addr || wd_w[g] !== e.data) begin
                  n_fail++;
                  $display("FAIL %s write: got addr=%0d data=%h, expected addr=%0d data=%h",
                           name, wa_w[g], wd_w[g], e.addr, e.data);
               end
            end
         end
         if (done_w[g]) seen = 1'b1;
         else begin
            @(negedge clk);
            c++;
         end
      end
      start_s[g] = 1'b0;
      n_tests++;
      if (!seen || c != lat) begin
         n_fail++;
         $display("FAIL %s done latency: got %0d (seen=%0d), expected %0d", name, c, seen, lat);
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s missing writes: got %0d outstanding, expected 0", name, exp_q.size());
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_tests++;
      if (done_w[0] !== 1'b0 || we_w[0] !== 1'b0 || ra_w[0] !== 11'd0 || ma_w[0] !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got done=%b we=%b ra=%0d ma=%h, expected all 0",
                  done_w[0], we_w[0], ra_w[0], ma_w[0]);
      end
      reset = 1'b0;
      @(negedge clk);
      n_tests++;
      if (done_w[0] !== 1'b0 || we_w[0] !== 1'b0 || ra_w[0] !== 11'd0) begin
         n_fail++;
         $display("FAIL idle_outputs: got done=%b we=%b ra=%0d, expected all 0",
                  done_w[0], we_w[0], ra_w[0]);
      end
   endtask

   task automatic check_decay(input bit g, input string name);
      for (int n = 0; n <= 12; n++) begin
         n_tests++;
         if (smem[g][int'(Y_ADDR) + n] !== 32'(4096 >> n)) begin
            n_fail++;
            $display("FAIL %s y[%0d]: got %0d, expected %0d", name, n,
                     $signed(smem[g][int'(Y_ADDR) + n]), 4096 >> n);
         end
      end
   endtask

   task automatic check_mem(input bit g, input int val, input string name);
      for (int q = 0; q < 10; q++) begin
         n_tests++;
         if (smem[g][int'(MEM_ADDR) + q] !== 32'(val)) begin
            n_fail++;
            $display("FAIL %s mem[%0d]: got %0d, expected %0d", name, q,
                     $signed(smem[g][int'(MEM_ADDR) + q]), val);
         end
      end
   endtask

   task automatic test_impulse();
      load_case(1'b0, 4096, 0, 4096, 0, 0);
      run_job(1'b0, 1'b0, 961, 1'b0, "impulse");
      check_mem(1'b0, 0, "impulse");
   endtask

   task automatic test_decay();
      load_case(1'b0, 4096, -2048, 4096, 0, 0);
      run_job(1'b0, 1'b0, 961, 1'b0, "decay");
      check_decay(1'b0, "decay");
   endtask

   task automatic test_update();
      load_case(1'b0, 4096, -4096, 0, 0, 1000);
      run_job(1'b0, 1'b1, 981, 1'b0, "update");
      check_mem(1'b0, 1000, "update");
   endtask

   task automatic test_saturate();
      load_case(1'b0, 32767, 0, 32767, 32767, 0);
      run_job(1'b0, 1'b0, 961, 1'b0, "saturate");
      n_tests++;
      if (smem[0][int'(Y_ADDR) + 39] !== 32'h0000_7FFF) begin
         n_fail++;
         $display("FAIL saturate y[39]: got %h, expected 00007fff", smem[0][int'(Y_ADDR) + 39]);
      end
      check_mem(1'b0, 0, "saturate");
   endtask

   task automatic test_in_place();
      load_case(1'b1, 4096, -2048, 4096, 0, 0);
      run_job(1'b1, 1'b0, 961, 1'b0, "in_place");
      check_decay(1'b1, "in_place");
   endtask

   task automatic test_reset_mid();
      int c;
      int writes;
      int dones;
      load_case(1'b0, 4096, -2048, 4096, 0, 0);
      @(negedge clk);
      start_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0;
      c = 1;
      while (c < 500) begin
         @(negedge clk);
         c++;
      end
      reset = 1'b1;
      @(negedge clk);
      reset  = 1'b0;
      writes = 0;
      dones  = 0;
      repeat (1100) begin
         if (we_w[0])   writes++;
         if (done_w[0]) dones++;
         @(negedge clk);
      end
      n_tests++;
      if (writes != 0) begin
         n_fail++;
         $display("FAIL reset_mid writes: got %0d, expected 0", writes);
      end
      n_tests++;
      if (dones != 0) begin
         n_fail++;
         $display("FAIL reset_mid done pulses: got %0d, expected 0", dones);
      end
   endtask

   task automatic test_back_to_back();
      load_case(1'b0, 4096, -2048, 4096, 0, 0);
      run_job(1'b0, 1'b0, 961, 1'b1, "restart_ignored_start");
      run_job(1'b0, 1'b0, 961, 1'b0, "back_to_back");
   endtask

   initial begin
      start_s[0]  = 1'b0;
      start_s[1]  = 1'b0;
      update_s[0] = 1'b0;
      update_s[1] = 1'b0;
      test_reset();
      test_impulse();
      test_decay();
      test_update();
      test_saturate();
      test_in_place();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
